// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and defaults for the instruction loader
//
// Purpose : Holds the loader FSM state type, the default address and word
//           widths, and a helper that converts a word width into hex digits.
// Ports   : none (package loader_pkg)
// Config  : LOADER_WRAP_EN (used by instr_loader) selects wrap-around
//           addressing instead of saturating at FULL.
package loader_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  // Number of hex digits that make up one word.
  function automatic int digits_of(input int data_w);
    return data_w / 4;
  endfunction

endpackage

// File: rtl/instr_loader_nibble_assembler.sv
// rtl/instr_loader_nibble_assembler.sv - hex digit shift register for word entry
//
// Purpose : Collects hex digits MSB first into a partial word and counts them.
//           The completing digit wraps the 2-bit count back to 0, so the
//           count reads 0 while a finished word waits to be written.
// Ports   : clk, reset      clock and synchronous active-high reset
//           clr             clear entry and count (priority over shift_en)
//           shift_en        shift nibble into the LSBs, bump the count
//           nibble[3:0]     digit value
//           entry           partial word (for display)
//           digit_cnt[1:0]  digits entered into the current word
//           last_digit      the next shift completes the word
//           next_word       value entry takes after the next shift
// Config  : none
module nibble_assembler
  import loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [3:0]        nibble,
  output logic [DATA_W-1:0] entry,
  output logic [1:0]        digit_cnt,
  output logic              last_digit,
  output logic [DATA_W-1:0] next_word
);

  // The count is two bits wide, so words of up to four digits are supported.
  localparam int DIGITS = digits_of(DATA_W);

  assign next_word  = {entry[DATA_W-5:0], nibble};
  assign last_digit = (digit_cnt == 2'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      entry     <= '0;
      digit_cnt <= 2'd0;
    end else if (shift_en) begin
      entry     <= next_word;
      digit_cnt <= last_digit ? 2'd0 : digit_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - hex keypad loader that writes words into instruction memory
//
// Purpose : While load is high, hex digits arriving on strobe are assembled
//           into words; each completed word is written to instruction memory
//           with a wr_req/wr_ack handshake at an auto-incrementing address.
// Ports   : clk, reset          clock and synchronous active-high reset
//           load                entry-mode level enable
//           strobe, nibble[3:0] one-cycle digit entry pulse and value
//           addr_clr            one-cycle pulse rewinding the address to 0
//           wr_ack              memory acknowledge of the pending write
//           wr_req, wr_addr,    write request, address and data
//           wr_data
//           entry, digit_cnt    partial word and digit count for display
//           full                last address has been written
// Config  : LOADER_WRAP_EN - when defined, the address wraps from all-ones
//           to 0 and full never asserts.
module instr_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              strobe,
  input  logic [3:0]        nibble,
  input  logic              addr_clr,
  input  logic              wr_ack,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] entry,
  output logic [1:0]        digit_cnt,
  output logic              full
);

  state_t            state;
  logic              shift_en;
  logic              asm_clr;
  logic              last_digit;
  logic [DATA_W-1:0] next_word;

  nibble_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (asm_clr),
    .shift_en   (shift_en),
    .nibble     (nibble),
    .entry      (entry),
    .digit_cnt  (digit_cnt),
    .last_digit (last_digit),
    .next_word  (next_word)
  );

  // Assembler controls. Digits are only taken in ENTRY with load still high;
  // the completed word stays visible on entry until the write is acked.
  always_comb begin
    shift_en = 1'b0;
    asm_clr  = 1'b0;
    case (state)
      ST_ENTRY: begin
        if (addr_clr || !load) asm_clr  = 1'b1;
        else                   shift_en = strobe;
      end
      ST_WRITE: asm_clr = wr_ack;
      default:  asm_clr = addr_clr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      full    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (addr_clr) begin
            wr_addr <= '0;
            full    <= 1'b0;
          end else if (load) begin
            state <= ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          if (addr_clr) begin
            wr_addr <= '0;
            full    <= 1'b0;
            state   <= ST_IDLE;
          end else if (!load) begin
            state <= ST_IDLE;
          end else if (strobe && last_digit) begin
            wr_data <= next_word;
            wr_req  <= 1'b1;
            state   <= ST_WRITE;
          end
        end

        // Address, data and request are frozen here; only wr_ack moves on.
        // A load drop does not abort the write, it only picks the exit state.
        ST_WRITE: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
`ifdef LOADER_WRAP_EN
            wr_addr <= wr_addr + 1'b1;
            state   <= load ? ST_ENTRY : ST_IDLE;
`else
            if (&wr_addr) begin
              full  <= 1'b1;
              state <= ST_FULL;
            end else begin
              wr_addr <= wr_addr + 1'b1;
              state   <= load ? ST_ENTRY : ST_IDLE;
            end
`endif
          end
        end

        ST_FULL: begin
          if (addr_clr) begin
            wr_addr <= '0;
            full    <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        strobe = 1'b0;
  logic [3:0]  nibble = 4'h0;
  logic        addr_clr = 1'b0;
  logic        wr_ack = 1'b0;
  logic        wr_req;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] entry;
  logic [1:0]  digit_cnt;
  logic        full;

  int vectors = 0;
  int miscompares = 0;
  int req_hi = 0;

`ifdef LOADER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  instr_loader dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .strobe    (strobe),
    .nibble    (nibble),
    .addr_clr  (addr_clr),
    .wr_ack    (wr_ack),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .entry     (entry),
    .digit_cnt (digit_cnt),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Model: a word is being typed (m_on), a finished word waits for ack
  // (m_busy), or the memory is full. Digits accumulate as entry*16+digit.
  bit          started = 1'b0;
  bit          m_on = 1'b0, m_busy = 1'b0, m_full = 1'b0, m_req = 1'b0;
  int          m_addr = 0, m_cnt = 0;
  logic [15:0] m_entry = '0, m_data = '0;

  always @(posedge clk) begin
    if (reset) begin
      started = 1'b1;
      m_on = 0; m_busy = 0; m_full = 0; m_req = 0;
      m_addr = 0; m_cnt = 0; m_entry = '0; m_data = '0;
    end else if (m_busy) begin
      if (wr_ack) begin
        m_busy = 0; m_req = 0; m_entry = '0; m_cnt = 0;
        if (m_addr == 127 && !WRAP) begin
          m_full = 1; m_on = 0;
        end else begin
          m_addr = (m_addr + 1) % 128;
          m_on = load;
        end
      end
    end else if (addr_clr) begin
      m_addr = 0; m_full = 0; m_entry = '0; m_cnt = 0; m_on = 0;
    end else if (m_full) begin
      m_full = 1;
    end else if (!m_on) begin
      m_on = load;
    end else if (!load) begin
      m_on = 0; m_entry = '0; m_cnt = 0;
    end else if (strobe) begin
      m_entry = (m_entry * 16 + 16'(nibble)) & 16'hFFFF;
      m_cnt = m_cnt + 1;
      if (m_cnt == 4) begin
        m_data = m_entry; m_req = 1; m_busy = 1; m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (wr_req === 1'b1) req_hi++;
    if (started) begin
      vectors++;
      if (wr_req !== m_req || wr_addr !== 7'(m_addr) || wr_data !== m_data ||
          entry !== m_entry || digit_cnt !== 2'(m_cnt) || full !== m_full) begin
        miscompares++;
        $display("FAIL outputs t=%0t got req=%b addr=%h data=%h entry=%h cnt=%0d full=%b want req=%b addr=%h data=%h entry=%h cnt=%0d full=%b",
                 $time, wr_req, wr_addr, wr_data, entry, digit_cnt, full,
                 m_req, 7'(m_addr), m_data, m_entry, 2'(m_cnt), m_full);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] n);
    strobe = 1'b1;
    nibble = n;
    tick();
    strobe = 1'b0;
  endtask

  task automatic press_word(input logic [15:0] w);
    press(w[15:12]); press(w[11:8]); press(w[7:4]); press(w[3:0]);
  endtask

  // Wait for wr_req, capture address/data, then ack after d further cycles.
  task automatic ack_after(input int d, input bit co_strobe,
                           output logic [6:0] a, output logic [15:0] dt);
    int k = 0;
    while (wr_req !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    a = wr_addr;
    dt = wr_data;
    if (wr_req !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL wr_req_timeout got 0 want 1");
      return;
    end
    repeat (d) tick();
    wr_ack = 1'b1;
    if (co_strobe) begin
      strobe = 1'b1;
      nibble = 4'h3;
    end
    tick();
    wr_ack = 1'b0;
    strobe = 1'b0;
  endtask

  logic [6:0]  a_seen;
  logic [15:0] d_seen;
  int          c0;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check("reset_state", {wr_req, full, wr_addr, wr_data, entry, digit_cnt},
          0);

    // Word 1234 at address 0, ack two cycles after the request.
    load = 1'b1;
    tick();
    press_word(16'h1234);
    c0 = req_hi;
    ack_after(2, 1'b0, a_seen, d_seen);
    tick();
    check("w1_addr", a_seen, 0);
    check("w1_data", d_seen, 16'h1234);
    check("w1_req_cycles", req_hi - c0, 3);
    check("w1_next_addr", wr_addr, 1);

    // Stray ack in ENTRY is ignored; A,B discarded by load drop.
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    press(4'hA); press(4'hB);
    check("ab_cnt", digit_cnt, 2);
    load = 1'b0; tick();
    load = 1'b1; tick();
    check("ab_discard", entry, 0);
    press_word(16'h5678);
    ack_after(1, 1'b0, a_seen, d_seen);
    check("w2_addr", a_seen, 1);
    check("w2_data", d_seen, 16'h5678);

    // Strobe F during WRITE and a strobe coincident with the ack.
    tick();
    press_word(16'h9ABC);
    press(4'hF);
    ack_after(1, 1'b1, a_seen, d_seen);
    check("w3_data", d_seen, 16'h9ABC);
    check("w3_cnt_after", digit_cnt, 0);

    // Load falls during WRITE: write completes, loader then idles.
    press_word(16'hDEAD);
    load = 1'b0;
    ack_after(0, 1'b0, a_seen, d_seen);
    press(4'h7);
    check("w4_idle_cnt", digit_cnt, 0);
    check("w4_addr", wr_addr, 4);
    load = 1'b1; tick();

    // addr_clr during WRITE is ignored.
    press_word(16'hBEEF);
    addr_clr = 1'b1; tick(); addr_clr = 1'b0;
    ack_after(0, 1'b0, a_seen, d_seen);
    check("w5_clr_ignored", wr_addr, 5);

    // addr_clr during ENTRY rewinds the address.
    tick();
    press(4'h1); press(4'h2);
    addr_clr = 1'b1; tick(); addr_clr = 1'b0;
    check("entry_clr_addr", wr_addr, 0);
    tick();

    // Reset while a write is pending.
    press_word(16'hCAFE);
    check("pre_reset_req", wr_req, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("reset_mid_write", {wr_req, wr_addr}, 0);
    tick();

    // Fill every address.
    for (int i = 0; i < 128; i++) begin
      press_word(16'(i * 257 + 16'h0100));
      ack_after(0, 1'b0, a_seen, d_seen);
      if (i == 127) check("last_addr", a_seen, 7'h7F);
    end
    press(4'h4); press(4'h5);
    if (WRAP) check("wrap_state", {full, wr_addr}, 0);
    else      check("full_state", {full, wr_addr}, {1'b1, 7'h7F});

    addr_clr = 1'b1; tick(); addr_clr = 1'b0;
    check("clr_from_full", {full, wr_addr}, 0);
    tick();
    press_word(16'h0F0F);
    ack_after(0, 1'b0, a_seen, d_seen);
    check("after_clr_addr", a_seen, 0);
    check("after_clr_data", d_seen, 16'h0F0F);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
